// File: rtl/csa_cpa_pipe.sv
// Pipelined carry-propagate adder: collapses a CSA (carry, sum) pair one CHUNK per stage, STAGES-cycle latency.
// A single global advance (out_ready | ~out_valid) moves or freezes every stage, so in_ready is combinational from out_ready.
module csa_cpa_pipe #(
    parameter  int SIZE   = 40,
    parameter  int CHUNK  = 16,
    localparam int STAGES = (SIZE + CHUNK - 1) / CHUNK
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_c,
    input  logic [SIZE-1:0] in_s,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_sum
);

    logic            w_adv;
    logic            w_vld_q [STAGES];
    logic            w_cy_q  [STAGES];
    logic [SIZE-1:0] w_a_q   [STAGES];
    logic [SIZE-1:0] w_b_q   [STAGES];
    logic [SIZE-1:0] w_res_q [STAGES];

    assign w_adv     = out_ready | ~w_vld_q[STAGES-1];
    assign in_ready  = w_adv;
    assign out_valid = w_vld_q[STAGES-1];
    assign out_sum   = w_res_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int W  = (k == STAGES - 1) ? (SIZE - LO) : CHUNK;

        logic            w_vld;
        logic            w_cy;
        logic [SIZE-1:0] w_a;
        logic [SIZE-1:0] w_b;
        logic [SIZE-1:0] w_res;
        logic [W:0]      w_sum;
        logic [SIZE-1:0] w_res_nxt;
        logic            w_unused;

        logic            r_vld;
        logic            r_cy;
        logic [SIZE-1:0] r_a;
        logic [SIZE-1:0] r_b;
        logic [SIZE-1:0] r_res;

        if (k == 0) begin : g_head
            assign w_vld = in_valid;
            assign w_cy  = 1'b0;
            assign w_a   = in_c;
            assign w_b   = in_s;
            assign w_res = '0;
        end else begin : g_body
            assign w_vld = w_vld_q[k-1];
            assign w_cy  = w_cy_q[k-1];
            assign w_a   = w_a_q[k-1];
            assign w_b   = w_b_q[k-1];
            assign w_res = w_res_q[k-1];
        end

        // Only chunk k of the operands is consumed here; the rest rides along for later stages.
        assign w_sum    = {1'b0, w_a[LO +: W]} + {1'b0, w_b[LO +: W]} + (W+1)'(w_cy);
        assign w_unused = ^{w_a, w_b};

        always_comb begin
            w_res_nxt           = w_res;
            w_res_nxt[LO +: W]  = w_sum[W-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_a   <= '0;
                r_b   <= '0;
                r_res <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld;
                r_cy  <= w_sum[W];
                r_a   <= w_a;
                r_b   <= w_b;
                r_res <= w_res_nxt;
            end
        end

        assign w_vld_q[k] = r_vld;
        assign w_cy_q[k]  = r_cy;
        assign w_a_q[k]   = r_a;
        assign w_b_q[k]   = r_b;
        assign w_res_q[k] = r_res;
    end

    // Top carry is dropped (mod 2^SIZE); the last stage's operand copies are never consumed.
    logic w_unused_tail;
    assign w_unused_tail = ^{w_a_q[STAGES-1], w_b_q[STAGES-1], w_cy_q[STAGES-1]};

endmodule

// File: tb/tb_csa_cpa_pipe.sv
// Bench for csa_cpa_pipe: directed vectors and corner sequences on the CHUNK=16 instance,
// then randomized traffic on CHUNK = 1, 7, 16, 40 instances against a queue-based adder model.
module tb_csa_cpa_pipe;

    localparam int SIZE = 40;
    localparam int ND   = 4;
    localparam int DM   = 2;    // CHUNK=16 instance (STAGES=3)

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [SIZE-1:0] in_c;
    logic [SIZE-1:0] in_s;
    logic            in_ready  [ND];
    logic            out_valid [ND];
    logic [SIZE-1:0] out_sum   [ND];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        csa_cpa_pipe #(
            .SIZE  (SIZE),
            .CHUNK ((g == 0) ? 1 : (g == 1) ? 7 : (g == 2) ? 16 : 40)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .in_c      (in_c),
            .in_s      (in_s),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_sum   (out_sum[g])
        );
    end

    typedef struct {
        logic [SIZE-1:0] c;
        logic [SIZE-1:0] s;
        logic [SIZE-1:0] sum;
    } vec_t;

    vec_t            vecs [8];
    logic [SIZE-1:0] sb [ND][$];
    logic            prev_stall [ND];
    logic [SIZE-1:0] prev_sum   [ND];
    int              nacc       [ND];

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d actual=%h required=%h", name, d, act, exp);
        end
    endtask

    // One isolated pair through the CHUNK=16 instance, checking the 3-edge latency.
    task automatic send_one(input logic [SIZE-1:0] c, input logic [SIZE-1:0] s, input logic [SIZE-1:0] exp);
        @(negedge clk);
        in_valid  = 1'b1;
        in_c      = c;
        in_s      = s;
        out_ready = 1'b1;
        #1 chk("accept_rdy", DM, 64'(in_ready[DM]), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_edge0_vld", DM, 64'(out_valid[DM]), 64'd0);
        @(negedge clk);
        chk("lat_edge1_vld", DM, 64'(out_valid[DM]), 64'd0);
        @(negedge clk);
        chk("lat_edge2_vld", DM, 64'(out_valid[DM]), 64'd1);
        chk("lat_edge2_sum", DM, 64'(out_sum[DM]), 64'(exp));
    endtask

    task automatic observe();
        for (int d = 0; d < ND; d++) begin
            if (prev_stall[d]) begin
                chk("stall_hold_vld", d, 64'(out_valid[d]), 64'd1);
                chk("stall_hold_sum", d, 64'(out_sum[d]), 64'(prev_sum[d]));
            end
            if (out_valid[d] && out_ready) begin
                if (sb[d].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rand_extra_output dut=%0d actual=%h required=none", d, out_sum[d]);
                end else begin
                    logic [SIZE-1:0] e;
                    e = sb[d].pop_front();
                    chk("rand_sum", d, 64'(out_sum[d]), 64'(e));
                end
            end
            if (in_valid && in_ready[d]) begin
                logic [SIZE-1:0] e;
                e = in_c + in_s;
                sb[d].push_back(e);
                nacc[d]++;
            end
            prev_stall[d] = out_valid[d] && !out_ready;
            prev_sum[d]   = out_sum[d];
        end
    endtask

    initial begin
        logic [SIZE-1:0] exp_q [$];
        logic [63:0]     r64;

        vecs[0] = '{40'h00_0000_FFFF, 40'h00_0000_0001, 40'h00_0001_0000};
        vecs[1] = '{40'hFF_FFFF_FFFF, 40'h00_0000_0001, 40'h00_0000_0000};
        vecs[2] = '{40'h00_FFFF_FFFF, 40'h00_0000_0001, 40'h01_0000_0000};
        vecs[3] = '{40'h12_3456_789A, 40'h01_1111_1111, 40'h13_4567_89AB};
        vecs[4] = '{40'h80_0000_0000, 40'h80_0000_0000, 40'h00_0000_0000};
        vecs[5] = '{40'hAA_AAAA_AAAA, 40'h55_5555_5555, 40'hFF_FFFF_FFFF};
        vecs[6] = '{40'h00_0000_0000, 40'h00_0000_0000, 40'h00_0000_0000};
        vecs[7] = '{40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFF, 40'hFF_FFFF_FFFE};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_c      = '0;
        in_s      = '0;
        for (int d = 0; d < ND; d++) begin
            prev_stall[d] = 1'b0;
            prev_sum[d]   = '0;
            nacc[d]       = 0;
        end

        #1;
        for (int d = 0; d < ND; d++) begin
            chk("reset_vld", d, 64'(out_valid[d]), 64'd0);
            chk("reset_sum", d, 64'(out_sum[d]), 64'd0);
            chk("reset_rdy", d, 64'(in_ready[d]), 64'd1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) send_one(vecs[i].c, vecs[i].s, vecs[i].sum);

        // Back-to-back: 8 pairs, expect 8 contiguous results.
        for (int i = 1; i <= 8; i++) exp_q.push_back(40'(i * 64'h1111_1111 + i));
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (n < 8) begin
                in_valid = 1'b1;
                in_c     = 40'((n + 1) * 64'h1111_1111);
                in_s     = 40'(n + 1);
            end else begin
                in_valid = 1'b0;
            end
            if (n >= 3 && n <= 10) begin
                chk("b2b_vld", DM, 64'(out_valid[DM]), 64'd1);
                chk("b2b_sum", DM, 64'(out_sum[DM]), 64'(exp_q[n-3]));
            end
            if (n == 11) chk("b2b_tail_vld", DM, 64'(out_valid[DM]), 64'd0);
        end

        // Stall: 3 in flight, 5 frozen cycles, then ordered drain.
        exp_q.delete();
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n < 3) begin
                in_valid  = 1'b1;
                in_c      = 40'h0F_0000_FFFF + 40'(n);
                in_s      = 40'h01_0001_0001 * 40'(n + 1);
                out_ready = 1'b1;
                exp_q.push_back(in_c + in_s);
            end else begin
                in_valid  = 1'b0;
                out_ready = (n >= 8);
            end
            #1;
            if (n >= 3 && n <= 7) begin
                chk("stall_rdy", DM, 64'(in_ready[DM]), 64'd0);
                chk("stall_vld", DM, 64'(out_valid[DM]), 64'd1);
                chk("stall_sum", DM, 64'(out_sum[DM]), 64'(exp_q[0]));
            end
            if (n >= 8 && n <= 10) begin
                chk("drain_vld", DM, 64'(out_valid[DM]), 64'd1);
                chk("drain_sum", DM, 64'(out_sum[DM]), 64'(exp_q[n-8]));
            end
            if (n == 11) chk("drain_tail_vld", DM, 64'(out_valid[DM]), 64'd0);
        end

        // Reset with two pairs in flight, first one sitting at the output.
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            in_valid  = (n < 2);
            in_c      = 40'h33_3333_3333;
            in_s      = 40'(n + 1);
            out_ready = (n < 2);
        end
        chk("prerst_vld", DM, 64'(out_valid[DM]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_vld", DM, 64'(out_valid[DM]), 64'd0);
        chk("midrst_sum", DM, 64'(out_sum[DM]), 64'd0);
        chk("midrst_rdy", DM, 64'(in_ready[DM]), 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("postrst_no_stale", DM, 64'(out_valid[DM]), 64'd0);
        end
        send_one(40'd5, 40'd7, 40'd12);

        // Randomized traffic on all four chunk widths.
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 16000; cyc++) begin
            @(negedge clk);
            r64 = {$urandom, $urandom};
            in_c = r64[SIZE-1:0];
            r64 = {$urandom, $urandom};
            in_s = r64[SIZE-1:0];
            case ($urandom_range(0, 7))
                0: in_c = '1;
                1: in_s = ~in_c;
                default: ;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1 observe();
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1 observe();
        end
        for (int d = 0; d < ND; d++) begin
            chk("rand_leftover", d, 64'(sb[d].size()), 64'd0);
            if (nacc[d] < 5000) begin
                total++;
                bad++;
                $display("FAIL rand_accepts dut=%0d actual=%0d required>=5000", d, nacc[d]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_cpa_pipe.md
# csa_cpa_pipe

Pipelined carry-propagate adder that collapses the redundant (carry, sum) pair from a carry-save adder tree into one binary word. It sits directly downstream of the CSA reduction trees in the NTT datapath (modular multiplier partial-product path), before modular reduction. The carry chain is split into fixed-width chunks with one register stage per chunk, so wide words close timing. Input and output use a valid/ready handshake, with stall support.

## Interface
- SIZE, 40, operand and result width in bits; equals the CSA tree output width.
- CHUNK, 16, bits added per pipeline stage; 1 ≤ CHUNK ≤ SIZE.
- STAGES, ceil(SIZE/CHUNK), derived and not overridden; pipeline depth. The last chunk holds the remaining SIZE − (STAGES−1)·CHUNK bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_c/in_s hold a valid pair.
- in_ready  output  1  the block accepts the pair this cycle.
- in_c  input  SIZE  CSA carry word (already aligned, no shift applied here).
- in_s  input  SIZE  CSA sum word.
- out_valid  output  1  out_sum holds a valid result.
- out_ready  input  1  downstream consumes out_sum this cycle.
- out_sum  output  SIZE  (in_c + in_s) mod 2^SIZE.

## Operation
- Global advance: adv = out_ready | ~out_valid. in_ready = adv, a combinational path from out_ready.
- A pair is accepted on a rising edge where in_valid & in_ready.
- All pipeline registers load only when adv = 1 and hold otherwise. The valid bits, data and carries shift together.
- Stage k (0..STAGES−1) adds chunk k of both operands plus the carry register from stage k−1. Stage 0 uses carry-in 0. Stage k produces result chunk k and a registered carry for stage k+1.
- Skew: the operand chunks still unconsumed and the result chunks already computed are carried forward in per-stage registers. In the output stage, all chunks belong to the same transaction.
- The carry out of the top chunk is discarded (mod 2^SIZE).
- When adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0. Bubbles are not collapsed: throughput is 1 per cycle only while adv stays high.
- in_valid while in_ready = 0: the pair is not accepted. The upstream holds it, and the block places no requirement on stability.

## Timing
- Latency: a pair accepted at edge t appears with out_valid = 1 after edge t+STAGES−1 (STAGES register levels, the last stage is the output register), assuming no stall. STAGES = 1 gives a plain registered adder with 1-cycle latency.
- Sustained throughput: 1 result per cycle while out_ready = 1.
- Stall: out_valid & ~out_ready freezes every stage. out_sum and out_valid hold stable until out_ready is seen.
- Simultaneous accept and drain in the same cycle is legal. The pipeline shifts by one.
- Reset: rst_n low clears, immediately and asynchronously, out_valid=0, out_sum=0, and all valid, carry and data registers to 0. in_ready reads 1 during reset. Transactions in flight are dropped, with no partial output. The first accept is possible on the first edge after rst_n rises.
- No combinational path from in_c/in_s to out_sum.

## Test plan
- Carry across chunks: SIZE=40, CHUNK=16 (STAGES=3). in_c=0x00_0000_FFFF, in_s=0x00_0000_0001, accepted at edge 0 → out_sum=0x00_0001_0000 with out_valid high after edge 2.
- Full wrap: in_c=0xFF_FFFF_FFFF, in_s=0x00_0000_0001 → out_sum=0x00_0000_0000. A ripple through all three chunks, top carry dropped.
- Back-to-back: out_ready=1, with 8 consecutive pairs (c=i·0x1111_1111, s=i) → 8 consecutive valid outputs in order, each equal to (c+s) mod 2^40, with no gaps.
- Stall: 3 pairs in flight, out_ready=0 for 5 cycles → in_ready=0, out_sum and out_valid frozen. On release, the 3 results drain in order with none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with 2 pairs in flight → out_valid drops to 0 without waiting for a clock. After release, no stale output appears, and a new pair 5+7 gives 12 at the nominal latency.
- Randomized: 10k random pairs, random in_valid/out_ready, CHUNK ∈ {1, 7, 16, 40} → scoreboard match against (c+s) mod 2^SIZE, with order preserved.
